fetch_queue: RTL and testbench

- Instruction fetch queue between the fetch unit and the IF/ID pipeline register.
- Buffers fetched bundles: instruction, PC, PC+4, prediction taken bit, predicted target and 2-bit predictor state.
- Presents the oldest bundle to the IF/ID register. Obeys that register's STALL and FLUSH so no fetched instruction is lost or duplicated.
- Back-pressures fetch when full.

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_queue_if.sv | 47 ++++
 rtl/fetch_queue_mem.sv | 32 +++
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue_pkg
// Brief   : Fetch bundle width, field offsets and default queue depth.
// Revision: 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    localparam int c_DEFAULT_DEPTH   = 4;

    localparam int c_INSTR_W         = 32;
    localparam int c_PC_W            = 32;
    localparam int c_PRED_ADDR_W     = 32;
    localparam int c_PRED_STATE_W    = 2;
    localparam int c_FETCH_BUNDLE_W  = c_INSTR_W + c_PC_W + c_PC_W + 1 + c_PRED_ADDR_W + c_PRED_STATE_W;

    // Bundle layout, LSB upward: state, target, taken, pc+4, pc, instr
    localparam int c_PRED_STATE_OFF  = 0;
    localparam int c_PRED_ADDR_OFF   = c_PRED_STATE_OFF + c_PRED_STATE_W;
    localparam int c_PRED_TAKEN_OFF  = c_PRED_ADDR_OFF + c_PRED_ADDR_W;
    localparam int c_PC_PLUS4_OFF    = c_PRED_TAKEN_OFF + 1;
    localparam int c_PC_OFF          = c_PC_PLUS4_OFF + c_PC_W;
    localparam int c_INSTR_OFF       = c_PC_OFF + c_PC_W;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue_if
// Brief   : Fetch-side push bundle and IF/ID-side head bundle of the queue.
// Revision: 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              FLUSH;
    logic              STALL;
    logic              Push_VALID;
    logic [31:0]       Instr1_IN;
    logic [31:0]       Instr_PC_IN;
    logic [31:0]       Instr_PC_Plus4_IN;
    logic              Branch_prediction_IN;
    logic [31:0]       Branch_prediction_addr_IN;
    logic [1:0]        Branch_predictions_IN;

    logic              Queue_FULL;
    logic [PTR_W:0]    Queue_COUNT;
    logic              Out_VALID;
    logic [31:0]       Instr1_IF;
    logic [31:0]       Instr_PC_IF;
    logic [31:0]       Instr_PC_Plus4_IF;
    logic              Branch_prediction_IF;
    logic [31:0]       Branch_prediction_addr_IF;
    logic [1:0]        Branch_predictions_IF;

    modport master (
        output FLUSH, STALL, Push_VALID, Instr1_IN, Instr_PC_IN, Instr_PC_Plus4_IN,
               Branch_prediction_IN, Branch_prediction_addr_IN, Branch_predictions_IN,
        input  Queue_FULL, Queue_COUNT, Out_VALID, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF,
               Branch_prediction_IF, Branch_prediction_addr_IF, Branch_predictions_IF
    );

    modport slave (
        input  FLUSH, STALL, Push_VALID, Instr1_IN, Instr_PC_IN, Instr_PC_Plus4_IN,
               Branch_prediction_IN, Branch_prediction_addr_IN, Branch_predictions_IN,
        output Queue_FULL, Queue_COUNT, Out_VALID, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF,
               Branch_prediction_IF, Branch_prediction_addr_IF, Branch_predictions_IF
    );

endinterface : fetch_queue_if
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue_mem
// Brief   : DEPTH x WIDTH register file, synchronous write, asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 131,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             CLK,
    input  wire logic             i_wr_en,
    input  wire logic [PTR_W-1:0] i_wr_addr,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic [PTR_W-1:0] i_rd_addr,
    output logic      [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are meaningless until written, so the array carries no reset.
    always_ff @(posedge CLK) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fetch_queue_mem
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : Instruction fetch queue feeding the IF/ID register; honours STALL
//           and FLUSH, back-pressures fetch when full. Define
//           FETCH_QUEUE_BYPASS_EN for zero-latency pass-through when empty.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH
) (
    input  wire logic      CLK,
    input  wire logic      RESET,
    fetch_queue_if.slave   fq
);

    localparam int             PTR_W        = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]            r_head;
    logic [PTR_W-1:0]            r_tail;
    logic [PTR_W:0]              r_count;

    logic [c_FETCH_BUNDLE_W-1:0] w_in_bundle;
    logic [c_FETCH_BUNDLE_W-1:0] w_rd_bundle;
    logic [c_FETCH_BUNDLE_W-1:0] w_head_bundle;
    logic                        w_full;
    logic                        w_empty;
    logic                        w_bypass;
    logic                        w_out_valid;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_wr_en;
    logic                        w_rd_en;

    assign w_in_bundle = {fq.Instr1_IN, fq.Instr_PC_IN, fq.Instr_PC_Plus4_IN,
                          fq.Branch_prediction_IN, fq.Branch_prediction_addr_IN,
                          fq.Branch_predictions_IN};

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty && fq.Push_VALID && !fq.FLUSH && !RESET;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_out_valid   = !w_empty || w_bypass;
    // An empty queue presents all-zero fields so a latched bubble is a NOP at PC 0
    assign w_head_bundle = w_bypass ? w_in_bundle :
                           (w_empty ? '0 : w_rd_bundle);

    assign w_push  = fq.Push_VALID && !w_full && !fq.FLUSH;
    assign w_pop   = w_out_valid && !fq.STALL && !fq.FLUSH;
    // A bypassed bundle consumed this cycle never touches storage; one held
    // by STALL is written normally and becomes the head.
    assign w_wr_en = w_push && !(w_bypass && !fq.STALL);
    assign w_rd_en = w_pop && !w_bypass;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (c_FETCH_BUNDLE_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .CLK       (CLK),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_tail),
        .i_wr_data (w_in_bundle),
        .i_rd_addr (r_head),
        .o_rd_data (w_rd_bundle)
    );

    always_ff @(posedge CLK) begin
        if (RESET || fq.FLUSH) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign fq.Queue_FULL                = w_full;
    assign fq.Queue_COUNT               = r_count;
    assign fq.Out_VALID                 = w_out_valid;
    assign fq.Instr1_IF                 = w_head_bundle[c_INSTR_OFF      +: c_INSTR_W];
    assign fq.Instr_PC_IF               = w_head_bundle[c_PC_OFF         +: c_PC_W];
    assign fq.Instr_PC_Plus4_IF         = w_head_bundle[c_PC_PLUS4_OFF   +: c_PC_W];
    assign fq.Branch_prediction_IF      = w_head_bundle[c_PRED_TAKEN_OFF];
    assign fq.Branch_prediction_addr_IF = w_head_bundle[c_PRED_ADDR_OFF  +: c_PRED_ADDR_W];
    assign fq.Branch_predictions_IF     = w_head_bundle[c_PRED_STATE_OFF +: c_PRED_STATE_W];

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_queue
// Brief   : Scoreboard bench for fetch_queue (DEPTH=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        bp;
        logic [31:0] bpaddr;
        logic [1:0]  bps;
    } bundle_t;

    logic CLK = 1'b0;
    logic RESET;

    int n_checks = 0;
    int n_errors = 0;

    bundle_t     sb[$];
    logic [31:0] emitted[$];

    fetch_queue_if #(.DEPTH(DEPTH)) fq ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .fq    (fq)
    );

    always #5 CLK = ~CLK;

    function automatic bundle_t mk(input logic [31:0] pc);
        bundle_t b;
        b.instr  = pc ^ 32'h1357_0013;
        b.pc     = pc;
        b.pc4    = pc + 32'd4;
        b.bp     = pc[2];
        b.bpaddr = pc + 32'h0000_0100;
        b.bps    = pc[3:2];
        return b;
    endfunction

    function automatic bundle_t head_out();
        bundle_t b;
        b.instr  = fq.Instr1_IF;
        b.pc     = fq.Instr_PC_IF;
        b.pc4    = fq.Instr_PC_Plus4_IF;
        b.bp     = fq.Branch_prediction_IF;
        b.bpaddr = fq.Branch_prediction_addr_IF;
        b.bps    = fq.Branch_predictions_IF;
        return b;
    endfunction

    // One clock of stimulus: compare the DUT head against the scoreboard, then
    // advance the scoreboard by what the queue should accept/emit this edge.
    task automatic cycle(input bundle_t b, input logic pv, input logic stall,
                         input logic flush, output logic accepted);
        bundle_t exp;
        bundle_t act;
        logic    exp_valid;
        logic    exp_full;
        logic    byp;
        logic    pop;
        fq.Push_VALID                = pv;
        fq.STALL                     = stall;
        fq.FLUSH                     = flush;
        fq.Instr1_IN                 = b.instr;
        fq.Instr_PC_IN               = b.pc;
        fq.Instr_PC_Plus4_IN         = b.pc4;
        fq.Branch_prediction_IN      = b.bp;
        fq.Branch_prediction_addr_IN = b.bpaddr;
        fq.Branch_predictions_IN     = b.bps;
        #1;
        exp_full = (sb.size() == DEPTH);
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (sb.size() == 0) && pv && !flush;
`endif
        exp_valid = (sb.size() != 0) || byp;
        exp = byp ? b : ((sb.size() != 0) ? sb[0] : '0);
        act = head_out();
        n_checks++;
        if (fq.Queue_COUNT !== (PTR_W+1)'(sb.size())) begin
            n_errors++;
            $display("FAIL count: actual=%0d expected=%0d", fq.Queue_COUNT, sb.size());
        end
        n_checks++;
        if (fq.Queue_FULL !== exp_full) begin
            n_errors++;
            $display("FAIL full: actual=%b expected=%b", fq.Queue_FULL, exp_full);
        end
        n_checks++;
        if (fq.Out_VALID !== exp_valid) begin
            n_errors++;
            $display("FAIL out_valid: actual=%b expected=%b", fq.Out_VALID, exp_valid);
        end
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL head: actual pc=%h bundle=%h expected pc=%h bundle=%h",
                     act.pc, act, exp.pc, exp);
        end
        pop      = exp_valid && !stall && !flush;
        accepted = pv && !exp_full && !flush;
        if (flush) begin
            sb.delete();
        end else if (byp) begin
            if (stall) sb.push_back(b);
            else       emitted.push_back(b.pc);
        end else begin
            if (pop) begin
                emitted.push_back(sb[0].pc);
                void'(sb.pop_front());
            end
            if (accepted) sb.push_back(b);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle(input logic stall, input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle('0, 1'b0, stall, 1'b0, acc);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            idle(1'b0, 1);
            guard++;
        end
        n_checks++;
        if (sb.size() != 0 || fq.Queue_COUNT !== '0) begin
            n_errors++;
            $display("FAIL drain: actual count=%0d expected 0", fq.Queue_COUNT);
        end
    endtask

    task automatic test_reset();
        RESET         = 1'b1;
        fq.Push_VALID = 1'b0;
        fq.STALL      = 1'b0;
        fq.FLUSH      = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (fq.Out_VALID !== 1'b0 || fq.Queue_COUNT !== '0 || fq.Queue_FULL !== 1'b0
            || head_out() !== '0) begin
            n_errors++;
            $display("FAIL reset: actual valid=%b count=%0d full=%b instr=%h expected 0/0/0/0",
                     fq.Out_VALID, fq.Queue_COUNT, fq.Queue_FULL, fq.Instr1_IF);
        end
        RESET = 1'b0;
        sb.delete();
        idle(1'b0, 3);
    endtask

    task automatic test_fill_stall();
        logic acc;
        emitted.delete();
        for (int i = 0; i < DEPTH; i++) cycle(mk(32'h0040_0000 + 32'(4*i)), 1'b1, 1'b1, 1'b0, acc);
        n_checks++;
        if (fq.Queue_FULL !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_full: actual=%b expected=1", fq.Queue_FULL);
        end
        cycle(mk(32'h0040_0010), 1'b1, 1'b1, 1'b0, acc);
        n_checks++;
        if (acc !== 1'b0 || fq.Queue_COUNT !== (PTR_W+1)'(DEPTH)) begin
            n_errors++;
            $display("FAIL fifth_push: actual count=%0d expected %0d", fq.Queue_COUNT, DEPTH);
        end
        idle(1'b0, DEPTH);
        n_checks++;
        if (emitted.size() != DEPTH || emitted[0] !== 32'h0040_0000 || emitted[DEPTH-1] !== 32'h0040_000C) begin
            n_errors++;
            $display("FAIL fill_order: actual n=%0d expected n=%0d first 400000 last 40000c",
                     emitted.size(), DEPTH);
        end
        drain();
    endtask

    task automatic test_simul_push_pop();
        logic acc;
        cycle(mk(32'h0040_0008), 1'b1, 1'b1, 1'b0, acc);
        cycle(mk(32'h0040_000C), 1'b1, 1'b1, 1'b0, acc);
        cycle(mk(32'h0040_0010), 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if (fq.Queue_COUNT !== (PTR_W+1)'(2) || fq.Instr_PC_IF !== 32'h0040_000C) begin
            n_errors++;
            $display("FAIL push_pop: actual count=%0d pc=%h expected count=2 pc=0040000c",
                     fq.Queue_COUNT, fq.Instr_PC_IF);
        end
        drain();
    endtask

    task automatic test_wrap_around();
        logic acc;
        int   idx = 0;
        int   guard = 0;
        emitted.delete();
        while (idx < 10 && guard < 60) begin
            cycle(mk(32'h0040_1000 + 32'(4*idx)), 1'b1, (guard % 2) == 0, 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        drain();
        n_checks++;
        if (emitted.size() != 10) begin
            n_errors++;
            $display("FAIL wrap_count: actual=%0d expected=10", emitted.size());
        end
        for (int i = 0; i < emitted.size(); i++) begin
            n_checks++;
            if (emitted[i] !== 32'h0040_1000 + 32'(4*i)) begin
                n_errors++;
                $display("FAIL wrap_order[%0d]: actual=%h expected=%h",
                         i, emitted[i], 32'h0040_1000 + 32'(4*i));
            end
        end
    endtask

    task automatic test_flush_priority();
        logic acc;
        for (int i = 0; i < 3; i++) cycle(mk(32'h0040_2000 + 32'(4*i)), 1'b1, 1'b1, 1'b0, acc);
        cycle(mk(32'h0040_2FFC), 1'b1, 1'b1, 1'b1, acc);
        n_checks++;
        if (fq.Queue_COUNT !== '0 || fq.Out_VALID !== 1'b0 || fq.Instr_PC_IF !== 32'h0) begin
            n_errors++;
            $display("FAIL flush: actual count=%0d valid=%b pc=%h expected 0/0/0",
                     fq.Queue_COUNT, fq.Out_VALID, fq.Instr_PC_IF);
        end
        idle(1'b0, 2);
    endtask

    task automatic test_reset_midop();
        logic acc;
        for (int i = 0; i < 2; i++) cycle(mk(32'h0040_3000 + 32'(4*i)), 1'b1, 1'b1, 1'b0, acc);
        RESET = 1'b1;
        fq.Push_VALID = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        sb.delete();
        n_checks++;
        if (fq.Queue_COUNT !== '0 || fq.Out_VALID !== 1'b0 || head_out() !== '0) begin
            n_errors++;
            $display("FAIL reset_midop: actual count=%0d valid=%b expected 0/0",
                     fq.Queue_COUNT, fq.Out_VALID);
        end
        idle(1'b0, 2);
    endtask

    task automatic test_prediction_fields();
        logic    acc;
        bundle_t b;
        b.instr  = 32'h0000_0063;
        b.pc     = 32'h0040_0020;
        b.pc4    = 32'h0040_0024;
        b.bp     = 1'b1;
        b.bpaddr = 32'h0040_0100;
        b.bps    = 2'b11;
        cycle(b, 1'b1, 1'b1, 1'b0, acc);
        n_checks++;
        if (fq.Branch_prediction_IF !== 1'b1 || fq.Branch_prediction_addr_IF !== 32'h0040_0100
            || fq.Branch_predictions_IF !== 2'b11) begin
            n_errors++;
            $display("FAIL pred_fields: actual bp=%b addr=%h st=%b expected 1/00400100/11",
                     fq.Branch_prediction_IF, fq.Branch_prediction_addr_IF, fq.Branch_predictions_IF);
        end
        drain();
`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty queue, no stall: consumed the same cycle, count stays zero
        cycle(mk(32'h0040_0030), 1'b1, 1'b0, 1'b0, acc);
        n_checks++;
        if (fq.Queue_COUNT !== '0) begin
            n_errors++;
            $display("FAIL bypass_count: actual=%0d expected=0", fq.Queue_COUNT);
        end
`endif
    endtask

    initial begin
        fq.Push_VALID                = 1'b0;
        fq.STALL                     = 1'b0;
        fq.FLUSH                     = 1'b0;
        fq.Instr1_IN                 = '0;
        fq.Instr_PC_IN               = '0;
        fq.Instr_PC_Plus4_IN         = '0;
        fq.Branch_prediction_IN      = 1'b0;
        fq.Branch_prediction_addr_IN = '0;
        fq.Branch_predictions_IN     = '0;
        RESET                        = 1'b1;
        @(negedge CLK);
        test_reset();
        test_fill_stall();
        test_simul_push_pop();
        test_wrap_around();
        test_flush_priority();
        test_reset_midop();
        test_prediction_fields();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
